// File: rtl/axi_wr_route_ctrl.sv
// Write-path routing controller for a 1-master / 2-slave AXI section.
// Decodes AW, steers AW/W demuxes and the B return mux, one transaction in flight.
module axi_wr_route_ctrl #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] SLV1_BASE = 32'h4000_0000,
    parameter logic [ADDR_W-1:0] SLV1_MASK = 32'hF000_0000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              s_awvalid,
    input  logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awready,
    input  logic [1:0]        m_awready,
    output logic              aw_dmx_en,
    output logic              aw_dmx_sel,
    input  logic              s_wvalid,
    input  logic              s_wlast,
    output logic              s_wready,
    input  logic [1:0]        m_wready,
    output logic              w_dmx_en,
    output logic              w_dmx_sel,
    input  logic [1:0]        m_bvalid,
    output logic [1:0]        m_bready,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic              b_mux_sel,
    output logic              busy,
    output logic              burst_err,
    output logic [15:0]       txn_cnt0,
    output logic [15:0]       txn_cnt1
);

    typedef enum logic [1:0] {StIdle, StAw, StW, StB} state_e;

    state_e      state_q, state_d;
    logic        sel_q, sel_d;
    logic [7:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic        addr_sel;

    // Only feeds sel_d, so s_awaddr never reaches an output combinationally.
    assign addr_sel = ((s_awaddr & SLV1_MASK) == SLV1_BASE);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
            beat_q  <= 8'd0;
            err_q   <= 1'b0;
            cnt0_q  <= 16'd0;
            cnt1_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        beat_d    = beat_q;
        err_d     = err_q;
        cnt0_d    = cnt0_q;
        cnt1_d    = cnt1_q;
        s_awready = 1'b0;
        aw_dmx_en = 1'b0;
        s_wready  = 1'b0;
        w_dmx_en  = 1'b0;
        s_bvalid  = 1'b0;
        m_bready  = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (s_awvalid) begin
                    sel_d   = addr_sel;
                    state_d = StAw;
                end
            end
            StAw: begin
                aw_dmx_en = 1'b1;
                s_awready = m_awready[sel_q];
                if (s_awvalid && m_awready[sel_q]) begin
                    beat_d  = 8'd0;
                    state_d = StW;
                end
            end
            StW: begin
                w_dmx_en = 1'b1;
                s_wready = m_wready[sel_q];
                if (s_wvalid && m_wready[sel_q]) begin
                    beat_d = beat_q + 8'd1;
                    if (s_wlast) begin
                        state_d = StB;
                    end else if (beat_q == 8'hFF) begin
                        // 256th beat without WLAST: force the burst closed.
                        err_d   = 1'b1;
                        state_d = StB;
                    end
                end
            end
            StB: begin
                s_bvalid        = m_bvalid[sel_q];
                m_bready[sel_q] = s_bready;
                if (m_bvalid[sel_q] && s_bready) begin
                    if (sel_q) begin
                        cnt1_d = cnt1_q + 16'd1;
                    end else begin
                        cnt0_d = cnt0_q + 16'd1;
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign aw_dmx_sel = sel_q;
    assign w_dmx_sel  = sel_q;
    assign b_mux_sel  = sel_q;
    assign busy       = (state_q != StIdle);
    assign burst_err  = err_q;
    assign txn_cnt0   = cnt0_q;
    assign txn_cnt1   = cnt1_q;

endmodule

// File: tb/tb_axi_wr_route_ctrl.sv
// Self-checking bench for axi_wr_route_ctrl: per-cycle vector table plus
// hand-written sequences for reset, missing WLAST and mid-burst reset.
module tb_axi_wr_route_ctrl;

    logic        ACLK;
    logic        ARESET;
    logic        s_awvalid;
    logic [31:0] s_awaddr;
    logic        s_awready;
    logic [1:0]  m_awready;
    logic        aw_dmx_en;
    logic        aw_dmx_sel;
    logic        s_wvalid;
    logic        s_wlast;
    logic        s_wready;
    logic [1:0]  m_wready;
    logic        w_dmx_en;
    logic        w_dmx_sel;
    logic [1:0]  m_bvalid;
    logic [1:0]  m_bready;
    logic        s_bvalid;
    logic        s_bready;
    logic        b_mux_sel;
    logic        busy;
    logic        burst_err;
    logic [15:0] txn_cnt0;
    logic [15:0] txn_cnt1;

    axi_wr_route_ctrl dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .s_awvalid  (s_awvalid),
        .s_awaddr   (s_awaddr),
        .s_awready  (s_awready),
        .m_awready  (m_awready),
        .aw_dmx_en  (aw_dmx_en),
        .aw_dmx_sel (aw_dmx_sel),
        .s_wvalid   (s_wvalid),
        .s_wlast    (s_wlast),
        .s_wready   (s_wready),
        .m_wready   (m_wready),
        .w_dmx_en   (w_dmx_en),
        .w_dmx_sel  (w_dmx_sel),
        .m_bvalid   (m_bvalid),
        .m_bready   (m_bready),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .b_mux_sel  (b_mux_sel),
        .busy       (busy),
        .burst_err  (burst_err),
        .txn_cnt0   (txn_cnt0),
        .txn_cnt1   (txn_cnt1)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    // {busy, aw_en, aw_sel, s_awready}_{w_en, w_sel, s_wready}_{s_bvalid, m_bready[1:0], b_sel}
    logic [10:0] act;
    assign act = {busy, aw_dmx_en, aw_dmx_sel, s_awready, w_dmx_en, w_dmx_sel, s_wready,
                  s_bvalid, m_bready, b_mux_sel};

    typedef struct {
        string       name;
        logic        awvalid;
        logic [31:0] addr;
        logic [1:0]  awready;
        logic        wvalid;
        logic        wlast;
        logic [1:0]  wready;
        logic [1:0]  bvalid;
        logic        bready;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests  = 0;
    int   failed = 0;

    function automatic vec_t mk(string name, logic awv, logic [31:0] addr, logic [1:0] awr,
                                logic wv, logic wl, logic [1:0] wr, logic [1:0] bv,
                                logic br, logic [10:0] exp);
        vec_t v;
        v.name = name; v.awvalid = awv; v.addr = addr; v.awready = awr;
        v.wvalid = wv; v.wlast = wl; v.wready = wr; v.bvalid = bv;
        v.bready = br; v.exp = exp;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic quiet();
        s_awvalid = 1'b0; s_awaddr = 32'h0; m_awready = 2'b00;
        s_wvalid = 1'b0; s_wlast = 1'b0; m_wready = 2'b00;
        m_bvalid = 2'b00; s_bready = 1'b0;
    endtask

    task automatic apply(vec_t v);
        s_awvalid = v.awvalid; s_awaddr = v.addr; m_awready = v.awready;
        s_wvalid = v.wvalid; s_wlast = v.wlast; m_wready = v.wready;
        m_bvalid = v.bvalid; s_bready = v.bready;
        #1;
        check(v.name, {21'd0, act}, {21'd0, v.exp});
    endtask

    // IDLE -> AW -> W with both slaves AW-ready; returns one cycle into W.
    task automatic do_aw(logic [31:0] addr);
        s_awvalid = 1'b1; s_awaddr = addr; m_awready = 2'b11;
        tick();
        tick();
        s_awvalid = 1'b0;
    endtask

    int busy_cycles = 0;
    int w_beats     = 0;

    initial begin
        // Slave 1, 4-beat burst, slave responds one cycle into B.
        vecs.push_back(mk("s1_idle", 1, 32'h4000_0010, 2'b11, 0, 0, 2'b11, 2'b00, 1, 11'b0000_000_0000));
        vecs.push_back(mk("s1_aw",   1, 32'h4000_0010, 2'b11, 0, 0, 2'b11, 2'b00, 1, 11'b1111_010_0001));
        vecs.push_back(mk("s1_w1",   0, 32'h4000_0010, 2'b11, 1, 0, 2'b11, 2'b00, 1, 11'b1010_111_0001));
        vecs.push_back(mk("s1_w2",   0, 32'h4000_0010, 2'b11, 1, 0, 2'b11, 2'b00, 1, 11'b1010_111_0001));
        vecs.push_back(mk("s1_w3",   0, 32'h4000_0010, 2'b11, 1, 0, 2'b11, 2'b00, 1, 11'b1010_111_0001));
        vecs.push_back(mk("s1_w4",   0, 32'h4000_0010, 2'b11, 1, 1, 2'b11, 2'b00, 1, 11'b1010_111_0001));
        vecs.push_back(mk("s1_bwait",0, 32'h4000_0010, 2'b11, 0, 0, 2'b11, 2'b00, 1, 11'b1010_010_0101));
        vecs.push_back(mk("s1_b",    0, 32'h4000_0010, 2'b11, 0, 0, 2'b11, 2'b10, 1, 11'b1010_010_1101));
        vecs.push_back(mk("s1_done", 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 11'b0010_010_0001));
        // Slave 0 with AW backpressure, early W, W backpressure and a stray slave-1 B.
        vecs.push_back(mk("s0_idle", 1, 32'h0000_0100, 2'b10, 1, 0, 2'b11, 2'b00, 0, 11'b0010_010_0001));
        vecs.push_back(mk("s0_awbp1",1, 32'h0000_0100, 2'b10, 1, 0, 2'b11, 2'b00, 0, 11'b1100_000_0000));
        vecs.push_back(mk("s0_awbp2",1, 32'h0000_0100, 2'b10, 1, 0, 2'b11, 2'b00, 0, 11'b1100_000_0000));
        vecs.push_back(mk("s0_awbp3",1, 32'h0000_0100, 2'b10, 1, 0, 2'b11, 2'b00, 0, 11'b1100_000_0000));
        vecs.push_back(mk("s0_aw",   1, 32'h0000_0100, 2'b11, 1, 0, 2'b11, 2'b00, 0, 11'b1101_000_0000));
        vecs.push_back(mk("s0_wstl1",0, 32'h0000_0100, 2'b00, 1, 1, 2'b10, 2'b00, 0, 11'b1000_100_0000));
        vecs.push_back(mk("s0_w1",   0, 32'h0000_0100, 2'b00, 1, 0, 2'b01, 2'b00, 0, 11'b1000_101_0000));
        vecs.push_back(mk("s0_wstl2",0, 32'h0000_0100, 2'b00, 1, 1, 2'b10, 2'b00, 0, 11'b1000_100_0000));
        vecs.push_back(mk("s0_w2",   0, 32'h0000_0100, 2'b00, 1, 1, 2'b01, 2'b00, 0, 11'b1000_101_0000));
        vecs.push_back(mk("s0_stray",0, 32'h0000_0100, 2'b00, 0, 0, 2'b00, 2'b10, 1, 11'b1000_000_0010));
        vecs.push_back(mk("s0_b",    0, 32'h0000_0100, 2'b00, 0, 0, 2'b00, 2'b11, 1, 11'b1000_000_1010));
        vecs.push_back(mk("s0_done", 0, 32'h0,         2'b00, 0, 0, 2'b00, 2'b00, 0, 11'b0000_000_0000));

        quiet();
        ARESET = 1'b0;
        #3 ARESET = 1'b1;
        #1;
        check("rst_outputs", {21'd0, act}, 32'd0);
        check("rst_cnt0", {16'd0, txn_cnt0}, 32'd0);
        check("rst_cnt1", {16'd0, txn_cnt1}, 32'd0);
        check("rst_err", {31'd0, burst_err}, 32'd0);
        tick();
        tick();
        #3 ARESET = 1'b0;
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            if (i <= 8) begin
                busy_cycles += int'(busy);
                w_beats     += int'(s_wvalid & s_wready);
            end
            tick();
        end
        quiet();
        check("s1_busy_cycles", busy_cycles, 32'd7);
        check("s1_w_beats", w_beats, 32'd4);
        check("tbl_cnt0", {16'd0, txn_cnt0}, 32'd1);
        check("tbl_cnt1", {16'd0, txn_cnt1}, 32'd1);

        // Missing WLAST on slave 1.
        do_aw(32'h4000_0000);
        s_wvalid = 1'b1; s_wlast = 1'b0; m_wready = 2'b11;
        for (int i = 0; i < 255; i++) tick();
        check("nolast_err_255", {31'd0, burst_err}, 32'd0);
        check("nolast_w_255", {31'd0, w_dmx_en}, 32'd1);
        tick();
        check("nolast_err_256", {31'd0, burst_err}, 32'd1);
        check("nolast_state_b", {21'd0, act}, {21'd0, 11'b1010_010_0001});
        s_wvalid = 1'b0; m_bvalid = 2'b10; s_bready = 1'b1;
        #1;
        check("nolast_bvalid", {31'd0, s_bvalid}, 32'd1);
        tick();
        check("nolast_cnt1", {16'd0, txn_cnt1}, 32'd2);
        check("nolast_idle", {31'd0, busy}, 32'd0);
        quiet();
        do_aw(32'h0000_0100);
        s_wvalid = 1'b1; s_wlast = 1'b1; m_wready = 2'b01;
        tick();
        s_wvalid = 1'b0; m_bvalid = 2'b01; s_bready = 1'b1;
        tick();
        quiet();
        check("sticky_cnt0", {16'd0, txn_cnt0}, 32'd2);
        check("sticky_err", {31'd0, burst_err}, 32'd1);

        // Reset during beat 2 of an 8-beat burst.
        do_aw(32'h4000_0020);
        s_wvalid = 1'b1; s_wlast = 1'b0; m_wready = 2'b11;
        tick();
        #3 ARESET = 1'b1;
        #1;
        check("midrst_outputs", {21'd0, act}, 32'd0);
        check("midrst_cnt0", {16'd0, txn_cnt0}, 32'd0);
        check("midrst_cnt1", {16'd0, txn_cnt1}, 32'd0);
        check("midrst_err", {31'd0, burst_err}, 32'd0);
        tick();
        tick();
        quiet();
        #3 ARESET = 1'b0;
        tick();
        check("post_rst_idle", {21'd0, act}, 32'd0);
        s_awvalid = 1'b1; s_awaddr = 32'h0000_0100; m_awready = 2'b01;
        tick();
        check("post_rst_aw", {21'd0, act}, {21'd0, 11'b1101_000_0000});
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b1; s_wlast = 1'b1; m_wready = 2'b01;
        #1;
        check("post_rst_w", {21'd0, act}, {21'd0, 11'b1000_101_0000});
        tick();
        s_wvalid = 1'b0; m_bvalid = 2'b01; s_bready = 1'b1;
        #1;
        check("post_rst_b", {21'd0, act}, {21'd0, 11'b1000_000_1010});
        tick();
        quiet();
        check("post_rst_cnt0", {16'd0, txn_cnt0}, 32'd1);
        check("post_rst_cnt1", {16'd0, txn_cnt1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
